// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: generates the CPU clock-enable pulse for a hobby CPU.
// A free-running divider produces ticks in RUN; the CPU can be paused,
// single-stepped from a debounced push button, or stopped at a breakpoint.
`timescale 1ns/1ps
module cpu_clock_ctrl #(
  parameter int WIDTH           = 25,
  parameter int PC_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          run_mode,
  input  logic [4:0]          div_sel,
  input  logic                step_key,
  input  logic                bp_en,
  input  logic [PC_WIDTH-1:0] bp_addr,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                cpu_tick,
  output logic                cpu_clock,
  output logic                halted,
  output logic                bp_hit,
  output logic [15:0]         tick_count
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES) + 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALT    = 2'd1,
    ST_BP_HALT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [15:0]      tick_count_q, tick_count_d;
  logic             db_key_q, db_key_d;
  logic [DBW-1:0]   db_cnt_q, db_cnt_d;
  logic             step_req_q, step_req_d;
  logic             bp_armed_q, bp_armed_d;
  logic             halted_q, halted_d;
  logic             bp_hit_q, bp_hit_d;

  logic [4:0]       tap_s;
  logic [WIDTH-1:0] mask_s;
  logic             tap_bit_s;
  logic             roll_s;
  logic             bp_match_s;

  // Clamp the divider tap and build the rollover mask for bits [tap:0].
  always_comb begin
    mask_s    = '0;
    tap_bit_s = 1'b0;
    if (int'(div_sel) >= WIDTH) begin
      tap_s = 5'(WIDTH - 1);
    end else begin
      tap_s = div_sel;
    end
    for (int i = 0; i < WIDTH; i++) begin
      mask_s[i] = (i <= int'(tap_s));
      if (i == int'(tap_s)) begin
        tap_bit_s = cnt_q[i];
      end else begin
        tap_bit_s = tap_bit_s;
      end
    end
    roll_s     = &(cnt_q | ~mask_s);
    bp_match_s = bp_en && bp_armed_q && (pc == bp_addr);
  end

  // Next-state logic: debouncer, breakpoint arming, run/halt FSM, tick counter.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tick_d       = 1'b0;
    db_key_d     = db_key_q;
    db_cnt_d     = '0;
    bp_armed_d   = bp_armed_q;

    // A level change is accepted only after it has held for the full window.
    if (step_key != db_key_q) begin
      if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
        db_key_d = step_key;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DBW'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
    step_req_d = db_key_d & ~db_key_q;

    // Re-arm once the CPU has been anywhere other than the breakpoint.
    if (pc != bp_addr) begin
      bp_armed_d = 1'b1;
    end else begin
      bp_armed_d = bp_armed_q;
    end

    case (state_q)
      ST_RUN: begin
        cnt_d = cnt_q + WIDTH'(1);
        // Breakpoint beats a mode change, which beats a rollover tick.
        if (bp_match_s) begin
          state_d = ST_BP_HALT;
        end else if (run_mode != 2'b00) begin
          state_d = ST_HALT;
        end else if (roll_s) begin
          tick_d = 1'b1;
        end else begin
          tick_d = 1'b0;
        end
      end
      ST_HALT: begin
        if (run_mode == 2'b00) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if ((run_mode == 2'b10) && step_req_q) begin
          tick_d = 1'b1;
        end else begin
          tick_d = 1'b0;
        end
      end
      ST_BP_HALT: begin
        // Only a step press leaves the breakpoint; run_mode picks the exit.
        if (step_req_q) begin
          tick_d     = 1'b1;
          bp_armed_d = 1'b0;
          if (run_mode == 2'b00) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_HALT;
          end
        end else begin
          state_d = ST_BP_HALT;
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase

    tick_count_d = tick_count_q + {15'd0, tick_q};
    halted_d     = (state_d != ST_RUN);
    bp_hit_d     = (state_d == ST_BP_HALT);
  end

  // All state, with synchronous reset taking priority over every event.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_HALT;
      cnt_q        <= '0;
      tick_q       <= 1'b0;
      tick_count_q <= 16'd0;
      db_key_q     <= 1'b0;
      db_cnt_q     <= '0;
      step_req_q   <= 1'b0;
      bp_armed_q   <= 1'b1;
      halted_q     <= 1'b1;
      bp_hit_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tick_q       <= tick_d;
      tick_count_q <= tick_count_d;
      db_key_q     <= db_key_d;
      db_cnt_q     <= db_cnt_d;
      step_req_q   <= step_req_d;
      bp_armed_q   <= bp_armed_d;
      halted_q     <= halted_d;
      bp_hit_q     <= bp_hit_d;
    end
  end

  // LED clock: divider tap while running, otherwise mirrors the tick pulse.
  always_comb begin
    if (state_q == ST_RUN) begin
      cpu_clock = tap_bit_s;
    end else begin
      cpu_clock = tick_q;
    end
  end

  assign cpu_tick   = tick_q;
  assign halted     = halted_q;
  assign bp_hit     = bp_hit_q;
  assign tick_count = tick_count_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Self-checking bench for cpu_clock_ctrl with a cycle-level reference model.
`timescale 1ns/1ps
module tb_cpu_clock_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  run_mode;
  logic [4:0]  div_sel;
  logic        step_key;
  logic        bp_en;
  logic [7:0]  bp_addr;
  logic [7:0]  pc;
  logic        cpu_tick, cpu_clock, halted, bp_hit;
  logic [15:0] tick_count;
  logic        s_tick, s_clock, s_halted, s_bp_hit;
  logic [15:0] s_tick_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (0 = RUN, 1 = HALT, 2 = BP_HALT)
  int    m_state;
  longint m_cnt;
  bit    m_tick;
  int    m_tc;
  bit    m_db;
  int    m_dbc;
  bit    m_req;
  bit    m_armed;

  cpu_clock_ctrl dut (
    .clock(clk), .reset(reset), .run_mode(run_mode), .div_sel(div_sel),
    .step_key(step_key), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .cpu_tick(cpu_tick), .cpu_clock(cpu_clock), .halted(halted),
    .bp_hit(bp_hit), .tick_count(tick_count)
  );

  cpu_clock_ctrl #(.WIDTH(4), .PC_WIDTH(8), .DEBOUNCE_CYCLES(4)) dut_small (
    .clock(clk), .reset(reset), .run_mode(run_mode), .div_sel(div_sel),
    .step_key(step_key), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .cpu_tick(s_tick), .cpu_clock(s_clock), .halted(s_halted),
    .bp_hit(s_bp_hit), .tick_count(s_tick_count)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_update();
    int d; longint per; int ns; longint nc; bit nt; bit narm; bit ndb; int ndbc;
    if (reset) begin
      m_state = 1; m_cnt = 0; m_tick = 0; m_tc = 0;
      m_db = 0; m_dbc = 0; m_req = 0; m_armed = 1;
      return;
    end
    d    = (int'(div_sel) >= 25) ? 24 : int'(div_sel);
    per  = longint'(1) << (d + 1);
    ns   = m_state; nc = m_cnt; nt = 0;
    narm = m_armed | (pc != bp_addr);
    if (m_state == 0) begin
      nc = (m_cnt + 1) % (longint'(1) << 25);
      if (bp_en && m_armed && pc == bp_addr) ns = 2;
      else if (run_mode != 2'b00) ns = 1;
      else if ((m_cnt % per) == per - 1) nt = 1;
    end else if (m_state == 1) begin
      if (run_mode == 2'b00) begin ns = 0; nc = 0; end
      else if (run_mode == 2'b10 && m_req) nt = 1;
    end else begin
      if (m_req) begin
        nt = 1; narm = 0;
        ns = (run_mode == 2'b00) ? 0 : 1;
      end
    end
    ndb = m_db; ndbc = 0;
    if (step_key != m_db) begin
      ndbc = m_dbc + 1;
      if (ndbc == 16) begin ndb = step_key; ndbc = 0; end
    end
    m_req   = ndb && !m_db;
    m_tc    = (m_tc + int'(m_tick)) % 65536;
    m_state = ns; m_cnt = nc; m_tick = nt; m_armed = narm;
    m_db    = ndb; m_dbc = ndbc;
  endtask

  function automatic logic [19:0] exp_vec();
    int d; bit c;
    d = (int'(div_sel) >= 25) ? 24 : int'(div_sel);
    c = (m_state == 0) ? bit'((m_cnt >> d) & 1) : m_tick;
    return {m_tick, c, (m_state != 0), (m_state == 2), 16'(m_tc)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [19:0] got;
    run_mode = 2'b00; div_sel = 5'd2; step_key = 1'b1; bp_en = 1'b1;
    bp_addr = 8'h10; pc = 8'h10;
    reset = 1'b1;
    cyc(); cyc(); cyc();
    got = {cpu_tick, cpu_clock, halted, bp_hit, tick_count};
    n_cmp++;
    if (got !== {1'b0, 1'b0, 1'b1, 1'b0, 16'h0000}) begin
      n_bad++;
      $display("FAIL reset_state: got %h expected %h", got, {1'b0, 1'b0, 1'b1, 1'b0, 16'h0000});
    end
    step_key = 1'b0; bp_en = 1'b0; pc = 8'h00;
    reset = 1'b0;
  endtask

  task automatic test_run();
    int nt; int last; int bad_gap;
    run_mode = 2'b00; div_sel = 5'd2; bp_en = 1'b0; step_key = 1'b0;
    do_reset();
    cyc();
    n_cmp++;
    if (halted !== 1'b0) begin
      n_bad++; $display("FAIL run_halted: got %b expected 0", halted);
    end
    nt = 0; last = -1; bad_gap = 0;
    for (int i = 2; i <= 33; i++) begin
      cyc();
      if (cpu_tick) begin
        if (last >= 0 && i - last != 8) bad_gap++;
        last = i; nt++;
      end
    end
    n_cmp++;
    if (nt != 4 || bad_gap != 0) begin
      n_bad++; $display("FAIL run_ticks: got %0d ticks (%0d bad gaps) expected 4 ticks 8 apart", nt, bad_gap);
    end
    cyc();
    n_cmp++;
    if (tick_count !== 16'd4) begin
      n_bad++; $display("FAIL run_tick_count: got %0d expected 4", tick_count);
    end
  endtask

  task automatic test_pause();
    int guard; int seen; int n;
    guard = 0;
    while (!(m_state == 0 && (m_cnt % 8) == 7) && guard < 20) begin
      cyc(); guard++;
    end
    n_cmp++;
    if (guard >= 20) begin
      n_bad++; $display("FAIL pause_find_rollover: got timeout expected rollover within 20");
    end
    run_mode = 2'b01;
    cyc();
    n_cmp++;
    if ({cpu_tick, halted} !== 2'b01) begin
      n_bad++; $display("FAIL pause_on_rollover: got tick=%b halted=%b expected tick=0 halted=1", cpu_tick, halted);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (cpu_tick || cpu_clock) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++; $display("FAIL pause_quiet: got %0d active cycles expected 0", seen);
    end
    // First cycle re-enters RUN with a cleared divider, then 8 RUN cycles.
    run_mode = 2'b00;
    n = 0;
    do begin cyc(); n++; end while (!cpu_tick && n < 40);
    n_cmp++;
    if (n != 9) begin
      n_bad++; $display("FAIL resume_latency: got %0d cycles expected 9", n);
    end
  endtask

  task automatic test_step_debounce();
    int nt; int pos; int k;
    run_mode = 2'b10; div_sel = 5'd0; bp_en = 1'b0; step_key = 1'b0;
    do_reset();
    nt = 0;
    for (int p = 0; p < 3; p++) begin
      step_key = 1'b1;
      for (int i = 0; i < 3; i++) begin cyc(); if (cpu_tick) nt++; end
      step_key = 1'b0;
      for (int i = 0; i < 3; i++) begin cyc(); if (cpu_tick) nt++; end
    end
    step_key = 1'b1; pos = -1;
    for (k = 1; k <= 20; k++) begin
      cyc();
      if (cpu_tick) begin nt++; pos = k; end
    end
    step_key = 1'b0;
    for (int i = 0; i < 20; i++) begin cyc(); if (cpu_tick) nt++; end
    n_cmp++;
    if (nt != 1 || tick_count !== 16'd1) begin
      n_bad++; $display("FAIL step_single_tick: got %0d ticks count=%0d expected 1 and 1", nt, tick_count);
    end
    n_cmp++;
    if (pos != 17) begin
      n_bad++; $display("FAIL step_latency: got tick at cycle %0d expected 17", pos);
    end
  endtask

  task automatic test_reset_mid_step();
    int guard; int nt;
    run_mode = 2'b10; step_key = 1'b0;
    do_reset();
    step_key = 1'b1; guard = 0;
    while (!m_req && guard < 30) begin cyc(); guard++; end
    reset = 1'b1; step_key = 1'b0;
    cyc();
    reset = 1'b0;
    nt = 0;
    for (int i = 0; i < 30; i++) begin cyc(); if (cpu_tick) nt++; end
    n_cmp++;
    if (nt != 0 || tick_count !== 16'd0 || guard >= 30) begin
      n_bad++; $display("FAIL reset_discards_step: got %0d ticks count=%0d (guard %0d) expected 0", nt, tick_count, guard);
    end
  endtask

  task automatic test_breakpoint();
    int nt; int n; int hits;
    run_mode = 2'b00; div_sel = 5'd1; bp_en = 1'b1; bp_addr = 8'h10;
    pc = 8'h05; step_key = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) cyc();
    pc = 8'h10;
    cyc();
    n_cmp++;
    if ({bp_hit, halted} !== 2'b11) begin
      n_bad++; $display("FAIL bp_halt: got bp_hit=%b halted=%b expected 1 1", bp_hit, halted);
    end
    nt = 0;
    for (int i = 0; i < 12; i++) begin
      run_mode = 2'(i % 4);
      cyc();
      if (cpu_tick) nt++;
    end
    n_cmp++;
    if (nt != 0 || bp_hit !== 1'b1) begin
      n_bad++; $display("FAIL bp_hold: got %0d ticks bp_hit=%b expected 0 ticks bp_hit=1", nt, bp_hit);
    end
    run_mode = 2'b00; step_key = 1'b1; n = 0;
    do begin cyc(); n++; end while (!cpu_tick && n < 30);
    n_cmp++;
    if ({cpu_tick, halted, bp_hit} !== 3'b100) begin
      n_bad++; $display("FAIL bp_step_resume: got tick=%b halted=%b bp_hit=%b expected 1 0 0", cpu_tick, halted, bp_hit);
    end
    hits = 0;
    for (int i = 0; i < 20; i++) begin cyc(); if (bp_hit || halted) hits++; end
    n_cmp++;
    if (hits != 0) begin
      n_bad++; $display("FAIL bp_no_rehalt: got %0d halted cycles expected 0", hits);
    end
    step_key = 1'b0;
    pc = 8'h11; cyc();
    pc = 8'h10; cyc();
    n_cmp++;
    if (bp_hit !== 1'b1) begin
      n_bad++; $display("FAIL bp_rearm: got bp_hit=%b expected 1", bp_hit);
    end
    bp_en = 1'b0;
  endtask

  task automatic test_clamp();
    int nt; int first; int last; int bad_gap; int main_act;
    run_mode = 2'b00; div_sel = 5'd31; bp_en = 1'b0; step_key = 1'b0;
    do_reset();
    nt = 0; first = -1; last = -1; bad_gap = 0; main_act = 0;
    for (int i = 1; i <= 64; i++) begin
      cyc();
      if (cpu_tick || cpu_clock) main_act++;
      if (s_tick) begin
        if (first < 0) first = i;
        if (last >= 0 && i - last != 16) bad_gap++;
        last = i; nt++;
      end
    end
    n_cmp++;
    if (nt != 3 || first != 17 || bad_gap != 0) begin
      n_bad++; $display("FAIL clamp_small: got %0d ticks first=%0d gaps_bad=%0d expected 3 17 0", nt, first, bad_gap);
    end
    n_cmp++;
    if (main_act != 0 || halted !== 1'b0) begin
      n_bad++; $display("FAIL clamp_main: got %0d active cycles halted=%b expected 0 0", main_act, halted);
    end
  endtask

  task automatic test_random();
    logic [19:0] got, exp;
    int hold; int bad_here;
    bp_addr = 8'h02; pc = 8'h00; run_mode = 2'b00; div_sel = 5'd1;
    bp_en = 1'b1; step_key = 1'b0;
    do_reset();
    hold = 0; bad_here = 0;
    for (int i = 0; i < 4000; i++) begin
      cyc();
      got = {cpu_tick, cpu_clock, halted, bp_hit, tick_count};
      exp = exp_vec();
      n_cmp++;
      if (got !== exp) begin
        n_bad++; bad_here++;
        if (bad_here < 10) $display("FAIL random_cycle_%0d: got %h expected %h", i, got, exp);
      end
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 31) == 0)
        run_mode = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      if ($urandom_range(0, 63) == 0) div_sel = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) pc = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 127) == 0) bp_en = ~bp_en;
      if (hold == 0) begin
        step_key = $urandom_range(0, 1);
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(10, 40);
      end else begin
        hold--;
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run_mode = 2'b00; div_sel = 5'd0; step_key = 1'b0;
    bp_en = 1'b0; bp_addr = 8'h00; pc = 8'h00;
    test_reset();
    test_run();
    test_pause();
    test_step_debounce();
    test_reset_mid_step();
    test_breakpoint();
    test_clamp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_clock_ctrl.md
CPU_CLOCK_CTRL -- requirements
Module: cpu_clock_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 25, divider counter width.
REQ-002 SHALL have parameter PC_WIDTH, default 8, width of pc and bp_addr.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16, stable cycles required on step_key.
REQ-004 Port: clock  in  1  single system clock; all logic on its rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: run_mode  in  2  00 RUN, 01 PAUSE, 10 STEP, 11 treated as PAUSE.
REQ-007 Port: div_sel  in  5  divider tap; values >= WIDTH clamp to WIDTH-1.
REQ-008 Port: step_key  in  1  raw, undebounced, active-high step button.
REQ-009 Port: bp_en  in  1  breakpoint enable.
REQ-010 Port: bp_addr  in  PC_WIDTH  breakpoint address.
REQ-011 Port: pc  in  PC_WIDTH  current CPU program counter.
REQ-012 Port: cpu_tick  out  1  registered one-cycle CPU clock-enable pulse.
REQ-013 Port: cpu_clock  out  1  visible CPU clock for LED.
REQ-014 Port: halted  out  1  high when state is not RUN.
REQ-015 Port: bp_hit  out  1  high in state BP_HALT.
REQ-016 Port: tick_count  out  16  number of cpu_tick pulses issued, wraps at 2^16.

Function
REQ-017 States SHALL be RUN, HALT, BP_HALT.
REQ-018 Divider counter SHALL increment by 1 each cycle in RUN only, be frozen in HALT/BP_HALT, and clear to 0 on HALT->RUN.
REQ-019 In RUN, a rollover SHALL be the cycle where counter bits [d:0] are all ones, d = clamped div_sel; tick period 2^(d+1) cycles.
REQ-020 In RUN, a rollover SHALL assert cpu_tick for exactly the next cycle, unless pause or breakpoint applies that cycle.
REQ-021 RUN->HALT when run_mode != 00; no tick issued on that transition cycle, even at rollover.
REQ-022 HALT->RUN when run_mode == 00.
REQ-023 Breakpoint flag bp_armed SHALL set in any cycle where pc != bp_addr, clear when leaving BP_HALT, and reset to 1.
REQ-024 RUN->BP_HALT when bp_en && bp_armed && pc == bp_addr; breakpoint wins over coincident rollover and over run_mode change.
REQ-025 Debouncer: db_key SHALL take step_key's value once step_key has differed from db_key for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-026 step_req SHALL be the one-cycle rising edge of db_key; cpu_tick SHALL assert the cycle after step_req.
REQ-027 In HALT with run_mode == 10, step_req SHALL issue one cpu_tick; state stays HALT; step_req ignored in HALT otherwise.
REQ-028 In BP_HALT, step_req SHALL issue one cpu_tick, clear bp_armed, and go to RUN if run_mode == 00 else HALT; run_mode alone SHALL NOT leave BP_HALT.
REQ-029 step_req in RUN SHALL be ignored.
REQ-030 cpu_clock SHALL equal counter bit d in RUN and equal cpu_tick otherwise.
REQ-031 tick_count SHALL increment by 1 in the cycle cpu_tick is high, wrapping 0xFFFF->0x0000.
REQ-032 div_sel change SHALL take effect the next cycle without clearing the counter.

Reset
REQ-033 On reset: state HALT, counter 0, cpu_tick 0, cpu_clock 0, halted 1, bp_hit 0, tick_count 0, db_key 0, debounce count 0, bp_armed 1.
REQ-034 Reset mid-step or mid-debounce SHALL discard the pending tick; reset has priority over every other event.

Verification
REQ-035 reset, run_mode=00, div_sel=2 -> halted=0 next cycle, cpu_tick every 8 cycles, tick_count=4 after 32 cycles in RUN.
REQ-036 RUN, div_sel=2, run_mode->01 on rollover cycle -> no cpu_tick, halted=1, counter frozen; run_mode->00 -> next tick after 8 cycles.
REQ-037 run_mode=10, step_key bouncing 3 pulses then high 20 cycles, DEBOUNCE_CYCLES=16 -> exactly one cpu_tick, tick_count=1.
REQ-038 RUN, bp_en=1, bp_addr=0x10, pc reaches 0x10 -> bp_hit=1, no further ticks; run_mode toggles keep BP_HALT.
REQ-039 In BP_HALT, run_mode=00, step pressed -> one tick, state RUN, no re-halt while pc stays 0x10, halts again when pc leaves and returns to 0x10.
REQ-040 div_sel=31 with WIDTH=25 -> behaves as div_sel=24, tick period 2^25 cycles.
